// File: rtl/note_render_pkg.sv
// note_render_pkg: shared sprite geometry, screen size and note slot types
package note_render_pkg;
  localparam int SPRITE_W = 20;
  localparam int SPRITE_H = 30;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  typedef logic [9:0] sprite_addr_t;
  typedef struct packed {
    logic       valid;
    logic [9:0] x;
    logic [9:0] y;
  } note_slot_t;
endpackage

// File: rtl/note_hit_detect.sv
// note_hit_detect: raster-vs-sprite hit test and sprite-local ROM address for one note slot
module note_hit_detect
  import note_render_pkg::*;
#(
  parameter int SW = SPRITE_W,
  parameter int SH = SPRITE_H
) (
  input  note_slot_t   slot_i,
  input  logic [9:0]   hcount_i,
  input  logic [9:0]   vcount_i,
  input  logic         active_video_i,
  output logic         hit_o,
  output sprite_addr_t addr_o
);
  logic [10:0] dx, dy;
  assign dx = {1'b0, hcount_i} - {1'b0, slot_i.x};
  assign dy = {1'b0, vcount_i} - {1'b0, slot_i.y};
  assign hit_o = slot_i.valid & active_video_i & (dx < 11'(SW)) & (dy < 11'(SH));
  assign addr_o = hit_o ? sprite_addr_t'(dy[9:0] * 10'(SW) + dx[9:0]) : '0;
endmodule

// File: rtl/note_sprite_renderer.sv
// note_sprite_renderer: note table, priority hit select and 3-stage ROM-aligned ink pipeline
module note_sprite_renderer
  import note_render_pkg::*;
#(
  parameter int NUM_NOTES = 8,
  parameter int SPRITE_W  = note_render_pkg::SPRITE_W,
  parameter int SPRITE_H  = note_render_pkg::SPRITE_H
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         note_we,
  input  logic [$clog2(NUM_NOTES)-1:0] note_idx,
  input  logic [9:0]                   note_x,
  input  logic [9:0]                   note_y,
  input  logic                         note_valid_in,
  input  logic                         frame_start,
  input  logic                         scroll_en,
  input  logic [9:0]                   hcount,
  input  logic [9:0]                   vcount,
  input  logic                         active_video,
  output logic [9:0]                   rom_addr,
  input  logic                         rom_pixel,
  output logic                         pixel_on,
  output logic [NUM_NOTES-1:0]         slot_free
);
  localparam int IW = $clog2(NUM_NOTES);
  note_slot_t           slots_q [NUM_NOTES];
  note_slot_t           slots_d [NUM_NOTES];
  logic [NUM_NOTES-1:0] hit;
  sprite_addr_t         addr [NUM_NOTES];
  sprite_addr_t         rom_addr_d, rom_addr_q;
  logic                 hit_any, hit_d1_q, hit_d2_q, pixel_on_q;

  for (genvar i = 0; i < NUM_NOTES; i++) begin : g_slot
    note_hit_detect #(.SW(SPRITE_W), .SH(SPRITE_H)) u_hit (
      .slot_i        (slots_q[i]),
      .hcount_i      (hcount),
      .vcount_i      (vcount),
      .active_video_i(active_video),
      .hit_o         (hit[i]),
      .addr_o        (addr[i])
    );
    assign slot_free[i] = ~slots_q[i].valid;
  end

  // lowest-index hitting slot owns the ROM address; overlaps never blend
  always_comb begin
    hit_any = |hit;
    rom_addr_d = '0;
    for (int n = NUM_NOTES - 1; n >= 0; n--) rom_addr_d = hit[n] ? addr[n] : rom_addr_d;
  end

  // scroll valid slots one pixel left per frame; a write to a slot overrides its scroll
  always_comb begin
    for (int n = 0; n < NUM_NOTES; n++) begin
      slots_d[n] = slots_q[n];
      if (frame_start && scroll_en && slots_q[n].valid) begin
        slots_d[n].valid = slots_q[n].x != '0;
        slots_d[n].x = (slots_q[n].x == '0) ? slots_q[n].x : slots_q[n].x - 10'd1;
      end
      if (note_we && note_idx == IW'(n)) slots_d[n] = '{valid: note_valid_in, x: note_x, y: note_y};
    end
  end

  // note table plus hit pipeline delayed to meet the ROM's registered pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NUM_NOTES; n++) slots_q[n] <= '0;
      rom_addr_q <= '0;
      hit_d1_q <= 1'b0;
      hit_d2_q <= 1'b0;
      pixel_on_q <= 1'b0;
    end else begin
      slots_q <= slots_d;
      rom_addr_q <= rom_addr_d;
      hit_d1_q <= hit_any;
      hit_d2_q <= hit_d1_q;
      pixel_on_q <= hit_d2_q & rom_pixel;
    end
  end

  assign rom_addr = rom_addr_q;
  assign pixel_on = pixel_on_q;
endmodule

// File: tb/tb_note_sprite_renderer.sv
// tb_note_sprite_renderer: directed scenarios plus randomized run against a behavioural note-table model
module tb_note_sprite_renderer;
  localparam int N = 8;
  logic clk = 1'b0;
  logic reset, note_we, note_valid_in, frame_start, scroll_en, active_video, rom_pixel;
  logic [2:0] note_idx;
  logic [9:0] note_x, note_y, hcount, vcount, rom_addr;
  logic pixel_on;
  logic [N-1:0] slot_free;
  int checks = 0, errors = 0;
  bit rom_mem [600];
  bit mv [N];
  int mx [N];
  int my [N];
  int e_addr = 0;
  bit e_pix = 0, p1 = 0, p2 = 0;

  always #5 clk = ~clk;

  note_sprite_renderer #(.NUM_NOTES(N)) dut (
    .clk(clk), .reset(reset), .note_we(note_we), .note_idx(note_idx), .note_x(note_x),
    .note_y(note_y), .note_valid_in(note_valid_in), .frame_start(frame_start),
    .scroll_en(scroll_en), .hcount(hcount), .vcount(vcount), .active_video(active_video),
    .rom_addr(rom_addr), .rom_pixel(rom_pixel), .pixel_on(pixel_on), .slot_free(slot_free)
  );

  always @(posedge clk) rom_pixel <= rom_mem[rom_addr];

  // reference: find first slot whose rectangle covers the raster, then apply scroll and write
  always @(posedge clk) begin
    int a, hc, vc;
    bit h;
    if (reset) begin
      for (int n = 0; n < N; n++) begin mv[n] = 0; mx[n] = 0; my[n] = 0; end
      e_addr = 0; e_pix = 0; p1 = 0; p2 = 0;
    end else begin
      hc = int'(hcount); vc = int'(vcount); h = 0; a = 0;
      for (int n = 0; n < N; n++)
        if (!h && mv[n] && active_video && hc >= mx[n] && hc < mx[n] + 20 && vc >= my[n] && vc < my[n] + 30) begin
          h = 1; a = (vc - my[n]) * 20 + (hc - mx[n]);
        end
      e_pix = p2; p2 = p1; p1 = h && rom_mem[a];
      e_addr = a;
      for (int n = 0; n < N; n++)
        if (frame_start && scroll_en && mv[n] && !(note_we && int'(note_idx) == n)) begin
          if (mx[n] == 0) mv[n] = 0; else mx[n] = mx[n] - 1;
        end
      if (note_we) begin
        mv[note_idx] = note_valid_in; mx[note_idx] = int'(note_x); my[note_idx] = int'(note_y);
      end
    end
  end

  task automatic tick; @(negedge clk); endtask

  task automatic idle;
    note_we = 0; frame_start = 0; scroll_en = 0; active_video = 0; note_valid_in = 0;
    note_idx = 0; note_x = 0; note_y = 0; hcount = 0; vcount = 0;
  endtask

  task automatic wr(input int idx, input int x, input int y, input bit v);
    note_we = 1; note_idx = 3'(idx); note_x = 10'(x); note_y = 10'(y); note_valid_in = v;
    tick; note_we = 0;
  endtask

  task automatic ras(input int h, input int v);
    hcount = 10'(h); vcount = 10'(v); active_video = 1;
    tick; active_video = 0;
  endtask

  task automatic test_reset;
    idle; reset = 1; tick; tick; reset = 0;
    checks++; if (slot_free !== 8'hFF) begin errors++; $display("FAIL reset_free got %h exp ff", slot_free); end
    checks++; if (rom_addr !== 10'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", rom_addr); end
    checks++; if (pixel_on !== 1'b0) begin errors++; $display("FAIL reset_pix got %b exp 0", pixel_on); end
  endtask

  task automatic test_single;
    wr(0, 100, 200, 1);
    checks++; if (slot_free !== 8'hFE) begin errors++; $display("FAIL single_free got %h exp fe", slot_free); end
    ras(100, 200);
    checks++; if (rom_addr !== 10'd0) begin errors++; $display("FAIL single_tl got %0d exp 0", rom_addr); end
    ras(119, 229);
    checks++; if (rom_addr !== 10'd599) begin errors++; $display("FAIL single_br got %0d exp 599", rom_addr); end
    checks++; if (pixel_on !== 1'b0) begin errors++; $display("FAIL single_pix_early got %b exp 0", pixel_on); end
    ras(120, 200);
    checks++; if (rom_addr !== 10'd0) begin errors++; $display("FAIL single_right got %0d exp 0", rom_addr); end
    checks++; if (pixel_on !== 1'b1) begin errors++; $display("FAIL single_pix_tl got %b exp 1", pixel_on); end
    ras(99, 200);
    checks++; if (pixel_on !== 1'b1) begin errors++; $display("FAIL single_pix_br got %b exp 1", pixel_on); end
    ras(100, 199);
    checks++; if (pixel_on !== 1'b0) begin errors++; $display("FAIL single_pix_right got %b exp 0", pixel_on); end
    tick;
    checks++; if (pixel_on !== 1'b0) begin errors++; $display("FAIL wrap_left_pix got %b exp 0", pixel_on); end
    tick;
    checks++; if (pixel_on !== 1'b0) begin errors++; $display("FAIL wrap_above_pix got %b exp 0", pixel_on); end
  endtask

  task automatic test_priority;
    wr(1, 50, 50, 1); wr(3, 55, 50, 1);
    ras(60, 60);
    checks++; if (rom_addr !== 10'd210) begin errors++; $display("FAIL prio_addr got %0d exp 210", rom_addr); end
    tick;
    checks++; if (pixel_on !== 1'b0) begin errors++; $display("FAIL prio_pix_t2 got %b exp 0", pixel_on); end
    tick;
    checks++; if (pixel_on !== 1'b1) begin errors++; $display("FAIL prio_pix_t3 got %b exp 1", pixel_on); end
  endtask

  task automatic test_scroll;
    wr(2, 1, 400, 1);
    ras(19, 400);
    checks++; if (rom_addr !== 10'd18) begin errors++; $display("FAIL scroll_pre got %0d exp 18", rom_addr); end
    frame_start = 1; scroll_en = 1; tick; frame_start = 0;
    ras(19, 400);
    checks++; if (rom_addr !== 10'd19) begin errors++; $display("FAIL scroll_x0 got %0d exp 19", rom_addr); end
    checks++; if (slot_free[2] !== 1'b0) begin errors++; $display("FAIL scroll_x0_free got %b exp 0", slot_free[2]); end
    frame_start = 1; tick; frame_start = 0;
    checks++; if (slot_free[2] !== 1'b1) begin errors++; $display("FAIL scroll_expire got %b exp 1", slot_free[2]); end
    ras(5, 400);
    checks++; if (rom_addr !== 10'd0) begin errors++; $display("FAIL scroll_nohit got %0d exp 0", rom_addr); end
    tick; tick;
    checks++; if (pixel_on !== 1'b0) begin errors++; $display("FAIL scroll_nohit_pix got %b exp 0", pixel_on); end
    scroll_en = 0;
  endtask

  task automatic test_write_scroll;
    wr(5, 300, 100, 1);
    note_we = 1; note_idx = 3'd4; note_x = 10'd400; note_y = 10'd300; note_valid_in = 1;
    frame_start = 1; scroll_en = 1; tick;
    note_we = 0; frame_start = 0; scroll_en = 0;
    ras(419, 300);
    checks++; if (rom_addr !== 10'd19) begin errors++; $display("FAIL ws_written got %0d exp 19", rom_addr); end
    ras(318, 100);
    checks++; if (rom_addr !== 10'd19) begin errors++; $display("FAIL ws_scrolled got %0d exp 19", rom_addr); end
  endtask

  task automatic test_inactive;
    hcount = 10'd410; vcount = 10'd310; active_video = 0; tick;
    checks++; if (rom_addr !== 10'd0) begin errors++; $display("FAIL inactive_addr got %0d exp 0", rom_addr); end
    tick; tick;
    checks++; if (pixel_on !== 1'b0) begin errors++; $display("FAIL inactive_pix got %b exp 0", pixel_on); end
  endtask

  task automatic test_midreset;
    hcount = 10'd405; vcount = 10'd310; active_video = 1; tick; tick; tick;
    checks++; if (pixel_on !== 1'b1) begin errors++; $display("FAIL midrst_pre got %b exp 1", pixel_on); end
    reset = 1; tick; reset = 0;
    checks++; if (pixel_on !== 1'b0) begin errors++; $display("FAIL midrst_pix got %b exp 0", pixel_on); end
    checks++; if (slot_free !== 8'hFF) begin errors++; $display("FAIL midrst_free got %h exp ff", slot_free); end
    tick; tick; tick;
    checks++; if (pixel_on !== 1'b0) begin errors++; $display("FAIL midrst_after got %b exp 0", pixel_on); end
    idle; tick;
  endtask

  task automatic test_random;
    logic [N-1:0] ef;
    int k;
    idle; tick; tick; tick; tick;
    for (int i = 0; i < 600; i++) rom_mem[i] = 1'($urandom);
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < N; n++) ef[n] = !mv[n];
      checks++; if (rom_addr !== 10'(e_addr)) begin errors++; $display("FAIL rnd_addr cyc %0d got %0d exp %0d", c, rom_addr, e_addr); end
      checks++; if (pixel_on !== e_pix) begin errors++; $display("FAIL rnd_pix cyc %0d got %b exp %b", c, pixel_on, e_pix); end
      checks++; if (slot_free !== ef) begin errors++; $display("FAIL rnd_free cyc %0d got %h exp %h", c, slot_free, ef); end
      reset = ($urandom % 500) == 0;
      note_we = ($urandom % 8) == 0;
      note_idx = 3'($urandom);
      note_x = 10'($urandom % 640);
      note_y = 10'($urandom % 480);
      note_valid_in = ($urandom % 4) != 0;
      frame_start = ($urandom % 40) == 0;
      scroll_en = ($urandom % 4) != 0;
      active_video = ($urandom % 8) != 0;
      if ($urandom % 4 != 0) begin
        k = int'($urandom % N);
        hcount = 10'(mx[k] + int'($urandom % 26) - 3);
        vcount = 10'(my[k] + int'($urandom % 36) - 3);
      end else begin
        hcount = 10'($urandom % 700);
        vcount = 10'($urandom % 520);
      end
      tick;
    end
    reset = 0; idle;
  endtask

  initial begin
    for (int i = 0; i < 600; i++) rom_mem[i] = 1;
    reset = 1; idle;
    test_reset;
    test_single;
    test_priority;
    test_scroll;
    test_write_scroll;
    test_inactive;
    test_midreset;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/note_sprite_renderer.md
# note_sprite_renderer

Scans the VGA raster against a table of on-screen notes and drives the address of the 20x30 quarter-note sprite ROM, then realigns the ROM's registered pixel with the raster to produce a per-pixel "note ink" flag. It sits between the VGA timing generator and the sprite ROM, upstream of the final colour mux. Notes are written by the game/controller logic and scroll left one pixel per frame.

## Interface
- NUM_NOTES, 8: note slots in the table (power of two, ≤16)
- SPRITE_W, 20: sprite width in pixels
- SPRITE_H, 30: sprite height in pixels
- clk  in  1  system/pixel clock
- reset  in  1  synchronous, active-high reset
- note_we  in  1  write strobe for one note slot
- note_idx  in  $clog2(NUM_NOTES)  slot written
- note_x  in  10  sprite left column, 0..639
- note_y  in  10  sprite top row, 0..479
- note_valid_in  in  1  1 loads a note, 0 clears the slot
- frame_start  in  1  one-cycle pulse at the start of each frame
- scroll_en  in  1  allows scrolling at frame_start
- hcount  in  10  current raster column
- vcount  in  10  current raster row
- active_video  in  1  raster inside visible area
- rom_addr  out  10  sprite ROM address (ROM registers it internally)
- rom_pixel  in  1  sprite ROM data, valid 1 cycle after rom_addr
- pixel_on  out  1  note ink at the raster position presented 3 cycles earlier
- slot_free  out  NUM_NOTES  bit i = slot i is empty

## Operation
- Slot state: valid, x[9:0], y[9:0]. The table is read by the hit logic and written by note_we and the scroll logic.
- Write: if note_we, then slot[note_idx] gets valid=note_valid_in, x=note_x, y=note_y.
- Scroll: on frame_start & scroll_en, each valid slot not being written this cycle does the following:
  - if x==0, valid is cleared;
  - otherwise x decrements by 1.
- Simultaneous write and scroll: the write wins for the addressed slot. Other slots scroll normally.
- Hit test per slot, 11-bit unsigned: dx=hcount−x, dy=vcount−y. Hit when valid & active_video & dx<SPRITE_W & dy<SPRITE_H. The unsigned wrap rejects raster positions left of or above the sprite.
- Priority: the lowest-index hitting slot wins. Overlapping notes do not OR their sprites.
- Address: rom_addr = dy*SPRITE_W + dx of the winner, always < 600. When no slot hits, rom_addr=0 and hit=0.
- pixel_on = registered (hit delayed to align with rom_pixel) & rom_pixel.
- slot_free = ~valid, registered state, combinationally exposed.

## Timing
- Pipeline stages, with raster inputs sampled at cycle t:
  - t+1: rom_addr and hit_d1 registered.
  - t+2: rom_pixel valid; hit_d2 registered.
  - t+3: pixel_on registered.
- Total latency is 3 cycles, fixed. The upstream colour mux delays its raster by 3 to match.
- Table updates are visible to the hit test on the cycle after the write/scroll edge.
- A write and a hit on the same cycle use the old slot contents.
- Reset values:
  - all slots valid=0, x=0, y=0;
  - slot_free all ones;
  - rom_addr=0, hit pipeline=0, pixel_on=0.
- Reset mid-frame: pixel_on is 0 from the cycle after reset is sampled, and stays 0 until 3 cycles after the first hit following reset release.
- No backpressure: every cycle advances the pipeline.

## Structure
- Shared package note_render_pkg holds:
  - SPRITE_W, SPRITE_H, SCREEN_W=640, SCREEN_H=480;
  - typedef note_slot_t {valid, x[9:0], y[9:0]};
  - typedef sprite_addr_t logic[9:0].
- Sub-module note_hit_detect, one per slot (generate loop): combinational dx/dy compute, hit flag, and local address.
- The top level does the priority select, pipeline registers, and table update.
- The sprite ROM is instantiated by the parent, not inside this block.

## Test plan
- Reset, then slot 0 written with x=100, y=200. Raster at (100,200) → rom_addr=0 at t+1. Raster at (119,229) → rom_addr=599. Raster at (120,200) → no hit, rom_addr=0.
- Raster at (99,200) and (100,199) with slot 0 as above → hit=0 (wrap rejection), pixel_on=0.
- Slots 1 and 3 overlapping at (50,50) and (55,50), raster (60,60) → slot 1 chosen: rom_addr=10*20+10=210. A model ROM returning 1 gives pixel_on=1 exactly 3 cycles after the raster input.
- Slot 2 at x=1 with scroll_en=1 → after frame_start #1 x=0, after frame_start #2 slot_free[2]=1 and no hits.
- note_we to slot 4 coinciding with frame_start & scroll_en → slot 4 holds the written x unchanged; slot 5 (x=300) becomes 299.
- active_video=0 with raster inside a valid sprite → pixel_on=0. Reset asserted mid-frame → pixel_on=0 the next cycle and slot_free all ones.
